// File: rtl/stream_mux_rr_if.sv
// Bundled handshake/data signals between N packet producers, the mux and one consumer.
// master drives channel inputs and out_ready; slave is the mux side.
interface stream_mux_rr_if #(
  parameter int WIDTH = 100,
  parameter int N     = 4,
  parameter int SELW  = 2
);
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_last;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_last;
  logic [SELW-1:0]      out_chan;
  logic                 out_ready;

  modport master (
    output mode, sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_chan
  );

  modport slave (
    input  mode, sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_chan
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 packet stream mux, fixed-select or round-robin, locked per packet; 1-cycle registered output.
// One IDLE arbitration bubble per packet; in_ready[grant] follows out_ready combinationally.
module stream_mux_rr #(
  parameter int WIDTH = 100,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic             clk,
  input  logic             reset,
  stream_mux_rr_if.slave   bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [SELW-1:0]   grant, grant_nxt;
  logic [SELW-1:0]   last_grant;
  logic [WIDTH-1:0]  grant_data;
  logic              grant_valid;
  logic              grant_last;
  logic              out_free;
  logic              accept;
  logic              rr_found;
  logic [SELW-1:0]   rr_cand;

  always_comb begin
    grant_data  = '0;
    grant_valid = 1'b0;
    grant_last  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant == SELW'(k)) begin
        grant_data  = bus.in_data[k*WIDTH +: WIDTH];
        grant_valid = bus.in_valid[k];
        grant_last  = bus.in_last[k];
      end
    end
  end

  assign out_free = !bus.out_valid || bus.out_ready;
  assign accept   = (state == LOCKED) && grant_valid && out_free;

  always_comb begin
    bus.in_ready = '0;
    if (state == LOCKED) begin
      for (int k = 0; k < N; k++) begin
        if (grant == SELW'(k)) bus.in_ready[k] = out_free;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_found  = 1'b0;
    rr_cand   = '0;
    case (state)
      IDLE: begin
        if (!bus.mode) begin
          // sel values at or beyond N match no channel, so no grant is made
          for (int k = 0; k < N; k++) begin
            if (bus.sel == SELW'(k) && bus.in_valid[k]) begin
              grant_nxt = SELW'(k);
              state_nxt = LOCKED;
            end
          end
        end else begin
          for (int i = 1; i <= N; i++) begin
            rr_cand = SELW'((int'(last_grant) + i) % N);
            for (int k = 0; k < N; k++) begin
              if (!rr_found && rr_cand == SELW'(k) && bus.in_valid[k]) begin
                rr_found  = 1'b1;
                grant_nxt = SELW'(k);
                state_nxt = LOCKED;
              end
            end
          end
        end
      end
      LOCKED: begin
        if (accept && grant_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= SELW'(N - 1);
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_chan  <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (accept) begin
        bus.out_data  <= grant_data;
        bus.out_last  <= grant_last;
        bus.out_chan  <= grant;
        bus.out_valid <= 1'b1;
        if (grant_last) last_grant <= grant;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: per-channel source queues, an expected-beat scoreboard,
// a table of arbitration vectors and hand sequences for reset, bubble, backpressure and lock.
module tb_stream_mux_rr;
  localparam int W    = 100;
  localparam int N    = 4;
  localparam int SELW = 2;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [W-1:0]    data;
    logic            last;
    logic [SELW-1:0] chan;
  } exp_t;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] mask;
    int         nexp;
    logic [7:0] order;
  } vec_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   nout;

  beat_t src_q [N][$];
  exp_t  exp_q [$];
  vec_t  tbl [9];

  stream_mux_rr_if #(.WIDTH(W), .N(N), .SELW(SELW)) bus ();

  stream_mux_rr #(.WIDTH(W), .N(N), .SELW(SELW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic load_pkt(input int ch, input int n, input int base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = W'(base + i);
      b.last = (i == n - 1);
      src_q[ch].push_back(b);
    end
  endtask

  task automatic expect_pkt(input int ch, input int n, input int base);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = W'(base + i);
      e.last = (i == n - 1);
      e.chan = SELW'(ch);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        bus.in_valid[k]            = 1'b1;
        bus.in_data[k*W +: W]      = src_q[k][0].data;
        bus.in_last[k]             = src_q[k][0].last;
      end else begin
        bus.in_valid[k]            = 1'b0;
        bus.in_data[k*W +: W]      = '0;
        bus.in_last[k]             = 1'b0;
      end
    end
  endtask

  task automatic flush_src();
    for (int k = 0; k < N; k++) src_q[k].delete();
  endtask

  // Handshakes are sampled at the falling edge, inputs updated just after the rising edge.
  task automatic step();
    logic [N-1:0] acc;
    exp_t e;
    beat_t b;
    @(negedge clk);
    acc = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      nout++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got chan=%0d data=%0h, required no beat", bus.out_chan, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {bus.out_data, bus.out_last, bus.out_chan}, e);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k] && src_q[k].size() > 0) b = src_q[k].pop_front();
    end
    drive();
  endtask

  task automatic run_done(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: got %0d beats pending, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_out(input string nm, input int val, input int budget);
    int n;
    n = 0;
    while (!(bus.out_valid === 1'b1 && bus.out_data === W'(val)) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: got out_data %0h, required %0h", nm, bus.out_data, val);
    end
  endtask

  initial begin
    int nout0;
    vectors     = 0;
    miscompares = 0;
    nout        = 0;

    // Last-grant pointer after the reset sequence is 3; orders below follow the rotation.
    tbl[0] = '{1'b1, 2'd0, 4'b1111, 4, 8'he4};
    tbl[1] = '{1'b1, 2'd0, 4'b0011, 2, 8'h04};
    tbl[2] = '{1'b1, 2'd0, 4'b1010, 2, 8'h07};
    tbl[3] = '{1'b1, 2'd0, 4'b0101, 2, 8'h02};
    tbl[4] = '{1'b0, 2'd2, 4'b1111, 1, 8'h02};
    tbl[5] = '{1'b0, 2'd1, 4'b0010, 1, 8'h01};
    tbl[6] = '{1'b1, 2'd0, 4'b1001, 2, 8'h03};
    tbl[7] = '{1'b1, 2'd0, 4'b1000, 1, 8'h03};
    tbl[8] = '{1'b1, 2'd0, 4'b0110, 2, 8'h09};

    // Reset held two cycles with every channel valid.
    reset         = 1'b1;
    bus.mode      = 1'b1;
    bus.sel       = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < N; k++) load_pkt(k, 1, k);
    for (int k = 0; k < N; k++) expect_pkt(k, 1, k);
    drive();
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_last_chan", {bus.out_last, bus.out_chan}, 0);
      chk("rst_in_ready", bus.in_ready, 0);
    end
    reset = 1'b0;
    run_done("reset_rr", 40);

    // Arbitration vectors: single-beat packets, data = 'h100*record + channel.
    for (int r = 0; r < 9; r++) begin
      int ch;
      bus.mode = tbl[r].mode;
      bus.sel  = tbl[r].sel;
      for (int k = 0; k < N; k++) if (tbl[r].mask[k]) load_pkt(k, 1, 'h100 * r + k);
      for (int i = 0; i < tbl[r].nexp; i++) begin
        ch = int'(tbl[r].order[2*i +: 2]);
        expect_pkt(ch, 1, 'h100 * r + ch);
      end
      drive();
      run_done("table", 40);
      flush_src();
      drive();
      step();
      step();
    end

    // Fixed select: bubble, then A, B, C back to back on channel 2.
    bus.mode = 1'b0;
    bus.sel  = 2'd2;
    load_pkt(2, 3, 'hA);
    expect_pkt(2, 3, 'hA);
    drive();
    chk("t2_idle_in_ready", bus.in_ready, 4'b0000);
    step();
    chk("t2_bubble_out_valid", bus.out_valid, 0);
    chk("t2_locked_in_ready", bus.in_ready, 4'b0100);
    step();
    chk("t2_beat_a", {bus.out_valid, bus.out_data, bus.out_last, bus.out_chan}, {1'b1, W'('hA), 1'b0, 2'd2});
    chk("t2_in_ready_a", bus.in_ready, 4'b0100);
    step();
    chk("t2_beat_b", {bus.out_valid, bus.out_data, bus.out_last, bus.out_chan}, {1'b1, W'('hB), 1'b0, 2'd2});
    step();
    chk("t2_beat_c", {bus.out_valid, bus.out_data, bus.out_last, bus.out_chan}, {1'b1, W'('hC), 1'b1, 2'd2});
    chk("t2_back_idle_in_ready", bus.in_ready, 4'b0000);
    run_done("t2", 10);

    // Backpressure in mid-packet on channel 3.
    bus.sel = 2'd3;
    nout0 = nout;
    load_pkt(3, 4, 4);
    expect_pkt(3, 4, 4);
    drive();
    wait_out("t4_wait5", 5, 20);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_hold_data", {bus.out_valid, bus.out_data}, {1'b1, W'(5)});
      chk("t4_hold_in_ready", bus.in_ready, 4'b0000);
    end
    bus.out_ready = 1'b1;
    run_done("t4", 20);
    chk("t4_beat_count", nout - nout0, 4);

    // Select change mid-packet is ignored until the locked packet finishes.
    bus.sel = 2'd1;
    load_pkt(1, 4, 'h10);
    load_pkt(3, 2, 'h30);
    expect_pkt(1, 4, 'h10);
    expect_pkt(3, 2, 'h30);
    drive();
    wait_out("t5_wait11", 'h11, 20);
    bus.sel = 2'd3;
    run_done("t5", 30);

    // Reset in mid-packet, then channel 0 wins first under round-robin.
    bus.mode = 1'b1;
    load_pkt(2, 4, 'h20);
    expect_pkt(2, 4, 'h20);
    drive();
    wait_out("t6_wait21", 'h21, 20);
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    step();
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_out_regs", {bus.out_data, bus.out_last, bus.out_chan}, 0);
    chk("t6_idle_in_ready", bus.in_ready, 4'b0000);
    exp_q.delete();
    flush_src();
    for (int k = 0; k < N; k++) load_pkt(k, 1, 'h40 + k);
    for (int k = 0; k < N; k++) expect_pkt(k, 1, 'h40 + k);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    drive();
    run_done("t6", 40);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
